// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: accumulates coin credit, vends against per-slot
// price and stock, returns change, refunds on cancel/timeout and raises coded alarms.
module vending_machine_multi #(
   parameter int NUM_PRODUCTS   = 4,
   parameter int MONEY_W        = 8,
   parameter int STOCK_W        = 4,
   parameter int SALES_W        = 16,
   parameter int TIMEOUT_CYCLES = 1000,
   localparam int SEL_W         = $clog2(NUM_PRODUCTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        coin_insert_button,
   input  logic [MONEY_W-1:0]          coin_value,
   input  logic [SEL_W-1:0]            product_sel,
   input  logic [NUM_PRODUCTS*MONEY_W-1:0] price_bus,
   input  logic                        confirm_button,
   input  logic                        cancel_button,
   input  logic                        restock_valid,
   input  logic [SEL_W-1:0]            restock_sel,
   input  logic [STOCK_W-1:0]          restock_count,
   output logic [2:0]                  state,
   output logic [MONEY_W-1:0]          coin_total,
   output logic [MONEY_W-1:0]          change,
   output logic                        change_valid,
   output logic                        product_dispensed,
   output logic [SEL_W-1:0]            dispensed_sel,
   output logic                        alarm,
   output logic [1:0]                  alarm_code,
   output logic [NUM_PRODUCTS-1:0]     sold_out,
   output logic [SALES_W-1:0]          total_sales
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [STOCK_W:0] STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_VEND    = 3'd2,
      S_REFUND  = 3'd3,
      S_FAULT   = 3'd4
   } state_t;

   state_t               cur;
   logic [TMR_W-1:0]     timer;
   logic [STOCK_W-1:0]   stock     [NUM_PRODUCTS];
   logic [STOCK_W-1:0]   stock_nxt [NUM_PRODUCTS];
   logic [STOCK_W:0]     stock_sum [NUM_PRODUCTS];
   logic [MONEY_W-1:0]   price_sel;
   logic                 stock_nz;
   logic                 credit_ok;
   logic                 vend_fire;
   logic [MONEY_W:0]     coin_sum;

   assign state = cur;

   // An out-of-range selection matches no slot, so it reads as zero stock (sold out).
   always_comb begin
      price_sel = '0;
      stock_nz  = 1'b0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         if (product_sel == SEL_W'(i)) begin
            price_sel = price_bus[i*MONEY_W +: MONEY_W];
            stock_nz  = (stock[i] != '0);
         end
      end
      credit_ok = (coin_total >= price_sel);
      coin_sum  = {1'b0, coin_total} + {1'b0, coin_value};
      vend_fire = (cur == S_COLLECT) && !cancel_button && confirm_button && stock_nz && credit_ok;
   end

   // Restock and a same-slot vend combine before saturating; vend implies stock >= 1.
   always_comb begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         stock_sum[i] = {1'b0, stock[i]};
         if (restock_valid && (restock_sel == SEL_W'(i)))
            stock_sum[i] = stock_sum[i] + {1'b0, restock_count};
         if (vend_fire && (product_sel == SEL_W'(i)))
            stock_sum[i] = stock_sum[i] - 1'b1;
         stock_nxt[i] = (stock_sum[i] > STOCK_MAX) ? STOCK_MAX[STOCK_W-1:0] : stock_sum[i][STOCK_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PRODUCTS; i++)
            stock[i] <= '0;
         sold_out <= '1;
      end else begin
         for (int i = 0; i < NUM_PRODUCTS; i++) begin
            stock[i]    <= stock_nxt[i];
            sold_out[i] <= (stock[i] == '0);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur               <= S_IDLE;
         timer             <= '0;
         coin_total        <= '0;
         change            <= '0;
         change_valid      <= 1'b0;
         product_dispensed <= 1'b0;
         dispensed_sel     <= '0;
         alarm             <= 1'b0;
         alarm_code        <= 2'd0;
         total_sales       <= '0;
      end else begin
         change            <= '0;
         change_valid      <= 1'b0;
         product_dispensed <= 1'b0;
         case (cur)
            S_IDLE: begin
               if (coin_insert_button) begin
                  coin_total <= coin_value;
                  timer      <= '0;
                  cur        <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               alarm      <= 1'b0;
               alarm_code <= 2'd0;
               if (cancel_button) begin
                  change       <= coin_total;
                  change_valid <= 1'b1;
                  timer        <= '0;
                  cur          <= S_REFUND;
               end else if (confirm_button) begin
                  timer <= '0;
                  if (!stock_nz) begin
                     alarm      <= 1'b1;
                     alarm_code <= 2'd2;
                     cur        <= S_FAULT;
                  end else if (!credit_ok) begin
                     alarm      <= 1'b1;
                     alarm_code <= 2'd1;
                     cur        <= S_FAULT;
                  end else begin
                     change            <= coin_total - price_sel;
                     change_valid      <= 1'b1;
                     product_dispensed <= 1'b1;
                     dispensed_sel     <= product_sel;
                     total_sales       <= total_sales + SALES_W'(price_sel);
                     cur               <= S_VEND;
                  end
               end else if (coin_insert_button) begin
                  timer <= '0;
                  if (coin_sum[MONEY_W]) begin
                     change       <= coin_value;
                     change_valid <= 1'b1;
                     alarm        <= 1'b1;
                     alarm_code   <= 2'd3;
                  end else begin
                     coin_total <= coin_sum[MONEY_W-1:0];
                  end
               end else if (timer == TMR_LAST) begin
                  change       <= coin_total;
                  change_valid <= 1'b1;
                  timer        <= '0;
                  cur          <= S_REFUND;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_VEND, S_REFUND: begin
               coin_total <= '0;
               cur        <= S_IDLE;
            end
            S_FAULT: begin
               if (cancel_button) begin
                  alarm        <= 1'b0;
                  alarm_code   <= 2'd0;
                  change       <= coin_total;
                  change_valid <= 1'b1;
                  cur          <= S_REFUND;
               end else if (!confirm_button) begin
                  alarm      <= 1'b0;
                  alarm_code <= 2'd0;
                  timer      <= '0;
                  cur        <= S_COLLECT;
               end
            end
            default: cur <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios followed by a randomized run
// checked against a cycle-level behavioural model of the vending rules.
module tb_vending_machine_multi;

   localparam int NP = 4;
   localparam int MW = 8;
   localparam int SW = 4;
   localparam int SAW = 16;
   localparam int TO = 8;
   localparam int SEL_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             coin_insert_button;
   logic [MW-1:0]    coin_value;
   logic [SEL_W-1:0] product_sel;
   logic [NP*MW-1:0] price_bus;
   logic             confirm_button;
   logic             cancel_button;
   logic             restock_valid;
   logic [SEL_W-1:0] restock_sel;
   logic [SW-1:0]    restock_count;
   logic [2:0]       state;
   logic [MW-1:0]    coin_total;
   logic [MW-1:0]    change;
   logic             change_valid;
   logic             product_dispensed;
   logic [SEL_W-1:0] dispensed_sel;
   logic             alarm;
   logic [1:0]       alarm_code;
   logic [NP-1:0]    sold_out;
   logic [SAW-1:0]   total_sales;

   int vectors = 0;
   int miscompares = 0;

   int      m_st, m_credit, m_timer, m_sales, m_change, m_dsel, m_code;
   int      m_stock [NP];
   bit      m_cv, m_pd, m_alarm;
   logic [NP-1:0] m_sold;

   vending_machine_multi #(
      .NUM_PRODUCTS(NP), .MONEY_W(MW), .STOCK_W(SW), .SALES_W(SAW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .coin_insert_button(coin_insert_button), .coin_value(coin_value),
      .product_sel(product_sel), .price_bus(price_bus),
      .confirm_button(confirm_button), .cancel_button(cancel_button),
      .restock_valid(restock_valid), .restock_sel(restock_sel), .restock_count(restock_count),
      .state(state), .coin_total(coin_total), .change(change), .change_valid(change_valid),
      .product_dispensed(product_dispensed), .dispensed_sel(dispensed_sel),
      .alarm(alarm), .alarm_code(alarm_code), .sold_out(sold_out), .total_sales(total_sales)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void model_reset();
      m_st = 0; m_credit = 0; m_timer = 0; m_sales = 0; m_change = 0;
      m_dsel = 0; m_code = 0; m_cv = 0; m_pd = 0; m_alarm = 0;
      for (int i = 0; i < NP; i++) m_stock[i] = 0;
      m_sold = '1;
   endfunction

   function automatic void model_refund();
      m_change = m_credit;
      m_cv     = 1;
      m_timer  = 0;
      m_st     = 3;
   endfunction

   // Predicts the registered outputs after the coming clock edge from the current inputs.
   function automatic void model_update();
      int  old_stock [NP];
      int  p, vsel, n;
      bit  vend;
      old_stock = m_stock;
      vend = 0;
      vsel = int'(product_sel);
      m_cv = 0; m_change = 0; m_pd = 0;
      case (m_st)
         0: if (coin_insert_button) begin
               m_credit = int'(coin_value); m_timer = 0; m_st = 1;
            end
         1: begin
            m_alarm = 0; m_code = 0;
            if (cancel_button) model_refund();
            else if (confirm_button) begin
               m_timer = 0;
               p = int'(price_bus[vsel*MW +: MW]);
               if (m_stock[vsel] == 0) begin m_st = 4; m_alarm = 1; m_code = 2; end
               else if (m_credit < p) begin m_st = 4; m_alarm = 1; m_code = 1; end
               else begin
                  vend = 1; m_change = m_credit - p; m_cv = 1; m_pd = 1; m_dsel = vsel;
                  m_sales = (m_sales + p) % 65536; m_st = 2;
               end
            end else if (coin_insert_button) begin
               m_timer = 0;
               if (m_credit + int'(coin_value) > 255) begin
                  m_change = int'(coin_value); m_cv = 1; m_alarm = 1; m_code = 3;
               end else m_credit = m_credit + int'(coin_value);
            end else if (m_timer == TO - 1) model_refund();
            else m_timer++;
         end
         2, 3: begin m_credit = 0; m_st = 0; end
         4: if (cancel_button) begin
               m_alarm = 0; m_code = 0; model_refund();
            end else if (!confirm_button) begin
               m_alarm = 0; m_code = 0; m_timer = 0; m_st = 1;
            end
         default: m_st = 0;
      endcase
      for (int i = 0; i < NP; i++) begin
         n = m_stock[i];
         if (restock_valid && int'(restock_sel) == i) n = n + int'(restock_count);
         if (vend && vsel == i) n = n - 1;
         if (n > 15) n = 15;
         m_stock[i] = n;
         m_sold[i]  = (old_stock[i] == 0);
      end
   endfunction

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      coin_insert_button = 0; coin_value = '0; confirm_button = 0; cancel_button = 0;
      restock_valid = 0; restock_sel = '0; restock_count = '0; product_sel = '0;
   endtask

   task automatic test_reset();
      rst = 1;
      idle_inputs();
      price_bus = {8'd1, 8'd50, 8'd100, 8'd25};
      model_reset();
      @(posedge clk);
      #1;
      vectors++; if (state !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
      vectors++; if (coin_total !== 8'd0 || change !== 8'd0 || change_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_money: got total=%0d change=%0d cv=%0d expected 0/0/0", coin_total, change, change_valid); end
      vectors++; if (product_dispensed !== 1'b0 || alarm !== 1'b0 || alarm_code !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_flags: got pd=%0d alarm=%0d code=%0d expected 0/0/0", product_dispensed, alarm, alarm_code); end
      vectors++; if (sold_out !== 4'hF || total_sales !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_stock: got sold_out=%b sales=%0d expected 1111/0", sold_out, total_sales); end
      rst = 0;
   endtask

   task automatic test_restock_vend();
      restock_valid = 1; restock_sel = 2'd2; restock_count = 4'd3;
      step();
      idle_inputs();
      vectors++; if (sold_out !== 4'b1111) begin miscompares++; $display("[TB] FAIL soldout_lag: got %b expected 1111", sold_out); end
      step();
      vectors++; if (sold_out !== 4'b1011) begin miscompares++; $display("[TB] FAIL soldout_after_restock: got %b expected 1011", sold_out); end
      coin_insert_button = 1; coin_value = 8'd20;
      step(); step(); step();
      idle_inputs();
      vectors++; if (state !== 3'd1 || coin_total !== 8'd60) begin miscompares++; $display("[TB] FAIL rv_credit: got state=%0d total=%0d expected 1/60", state, coin_total); end
      confirm_button = 1; product_sel = 2'd2;
      step();
      idle_inputs();
      vectors++; if (state !== 3'd2 || product_dispensed !== 1'b1 || dispensed_sel !== 2'd2) begin miscompares++; $display("[TB] FAIL rv_vend: got state=%0d pd=%0d sel=%0d expected 2/1/2", state, product_dispensed, dispensed_sel); end
      vectors++; if (change_valid !== 1'b1 || change !== 8'd10) begin miscompares++; $display("[TB] FAIL rv_change: got cv=%0d change=%0d expected 1/10", change_valid, change); end
      vectors++; if (total_sales !== 16'd50) begin miscompares++; $display("[TB] FAIL rv_sales: got %0d expected 50", total_sales); end
      step();
      vectors++; if (state !== 3'd0 || coin_total !== 8'd0 || product_dispensed !== 1'b0 || change_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rv_idle: got state=%0d total=%0d pd=%0d cv=%0d expected 0/0/0/0", state, coin_total, product_dispensed, change_valid); end
   endtask

   task automatic test_insufficient();
      coin_insert_button = 1; coin_value = 8'd30;
      step();
      idle_inputs();
      confirm_button = 1; product_sel = 2'd2;
      step();
      vectors++; if (state !== 3'd4 || alarm !== 1'b1 || alarm_code !== 2'd1 || coin_total !== 8'd30) begin miscompares++; $display("[TB] FAIL insuf_fault: got state=%0d alarm=%0d code=%0d total=%0d expected 4/1/1/30", state, alarm, alarm_code, coin_total); end
      step();
      vectors++; if (state !== 3'd4 || alarm !== 1'b1) begin miscompares++; $display("[TB] FAIL insuf_hold: got state=%0d alarm=%0d expected 4/1", state, alarm); end
      confirm_button = 0;
      step();
      vectors++; if (state !== 3'd1 || alarm !== 1'b0 || coin_total !== 8'd30) begin miscompares++; $display("[TB] FAIL insuf_release: got state=%0d alarm=%0d total=%0d expected 1/0/30", state, alarm, coin_total); end
      coin_insert_button = 1; coin_value = 8'd20;
      step();
      coin_insert_button = 0; confirm_button = 1;
      step();
      idle_inputs();
      vectors++; if (state !== 3'd2 || change_valid !== 1'b1 || change !== 8'd0 || total_sales !== 16'd100) begin miscompares++; $display("[TB] FAIL insuf_vend: got state=%0d cv=%0d change=%0d sales=%0d expected 2/1/0/100", state, change_valid, change, total_sales); end
      step();
   endtask

   task automatic test_sold_out();
      coin_insert_button = 1; coin_value = 8'd25;
      step();
      idle_inputs();
      confirm_button = 1; product_sel = 2'd0;
      step();
      confirm_button = 0; cancel_button = 1;
      vectors++; if (state !== 3'd4 || alarm !== 1'b1 || alarm_code !== 2'd2) begin miscompares++; $display("[TB] FAIL soldout_alarm: got state=%0d alarm=%0d code=%0d expected 4/1/2", state, alarm, alarm_code); end
      step();
      cancel_button = 0;
      vectors++; if (state !== 3'd3 || change_valid !== 1'b1 || change !== 8'd25 || alarm !== 1'b0) begin miscompares++; $display("[TB] FAIL soldout_refund: got state=%0d cv=%0d change=%0d alarm=%0d expected 3/1/25/0", state, change_valid, change, alarm); end
      step();
      vectors++; if (state !== 3'd0 || change_valid !== 1'b0 || coin_total !== 8'd0) begin miscompares++; $display("[TB] FAIL soldout_idle: got state=%0d cv=%0d total=%0d expected 0/0/0", state, change_valid, coin_total); end
   endtask

   task automatic test_overflow();
      coin_insert_button = 1; coin_value = 8'd200;
      step();
      coin_value = 8'd50;
      step();
      coin_value = 8'd10;
      step();
      coin_insert_button = 0;
      vectors++; if (state !== 3'd1 || coin_total !== 8'd250 || change_valid !== 1'b1 || change !== 8'd10) begin miscompares++; $display("[TB] FAIL ovf_reject: got state=%0d total=%0d cv=%0d change=%0d expected 1/250/1/10", state, coin_total, change_valid, change); end
      vectors++; if (alarm !== 1'b1 || alarm_code !== 2'd3) begin miscompares++; $display("[TB] FAIL ovf_alarm: got alarm=%0d code=%0d expected 1/3", alarm, alarm_code); end
      step();
      vectors++; if (alarm !== 1'b0 || change_valid !== 1'b0 || coin_total !== 8'd250) begin miscompares++; $display("[TB] FAIL ovf_pulse: got alarm=%0d cv=%0d total=%0d expected 0/0/250", alarm, change_valid, coin_total); end
      coin_insert_button = 1; coin_value = 8'd5;
      step();
      coin_insert_button = 0;
      vectors++; if (coin_total !== 8'd255 || alarm !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_exact: got total=%0d alarm=%0d expected 255/0", coin_total, alarm); end
      cancel_button = 1;
      step();
      cancel_button = 0;
      vectors++; if (state !== 3'd3 || change !== 8'd255) begin miscompares++; $display("[TB] FAIL ovf_refund: got state=%0d change=%0d expected 3/255", state, change); end
      step();
   endtask

   task automatic test_timeout();
      coin_insert_button = 1; coin_value = 8'd15;
      step();
      idle_inputs();
      for (int i = 0; i < TO - 1; i++) step();
      vectors++; if (state !== 3'd1 || change_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_early: got state=%0d cv=%0d expected 1/0", state, change_valid); end
      step();
      vectors++; if (state !== 3'd3 || change_valid !== 1'b1 || change !== 8'd15) begin miscompares++; $display("[TB] FAIL timeout_refund: got state=%0d cv=%0d change=%0d expected 3/1/15", state, change_valid, change); end
      step();
   endtask

   task automatic buy_slot3();
      coin_insert_button = 1; coin_value = 8'd1;
      step();
      coin_insert_button = 0; confirm_button = 1; product_sel = 2'd3;
      step();
      confirm_button = 0;
      step();
   endtask

   task automatic test_back_to_back();
      restock_valid = 1; restock_sel = 2'd3; restock_count = 4'd1;
      step();
      idle_inputs();
      coin_insert_button = 1; coin_value = 8'd5;
      step();
      coin_insert_button = 0; confirm_button = 1; product_sel = 2'd3;
      restock_valid = 1; restock_sel = 2'd3; restock_count = 4'd2;
      step();
      idle_inputs();
      vectors++; if (state !== 3'd2 || change !== 8'd4 || dispensed_sel !== 2'd3) begin miscompares++; $display("[TB] FAIL same_slot_vend: got state=%0d change=%0d sel=%0d expected 2/4/3", state, change, dispensed_sel); end
      step();
      buy_slot3();
      vectors++; if (sold_out[3] !== 1'b0) begin miscompares++; $display("[TB] FAIL same_slot_stock2: got sold_out[3]=%0d expected 0", sold_out[3]); end
      buy_slot3();
      vectors++; if (sold_out[3] !== 1'b1) begin miscompares++; $display("[TB] FAIL same_slot_stock0: got sold_out[3]=%0d expected 1", sold_out[3]); end
      coin_insert_button = 1; coin_value = 8'd7;
      step();
      coin_insert_button = 0;
      rst = 1;
      #1;
      model_reset();
      vectors++; if (state !== 3'd0 || coin_total !== 8'd0 || total_sales !== 16'd0 || sold_out !== 4'hF || alarm !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset: got state=%0d total=%0d sales=%0d sold_out=%b alarm=%0d expected 0/0/0/1111/0", state, coin_total, total_sales, sold_out, alarm); end
      #2;
      rst = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < NP; i++) price_bus[i*MW +: MW] = 8'($urandom_range(0, 120));
      for (int c = 0; c < 3000; c++) begin
         coin_insert_button = ($urandom_range(0, 99) < 35);
         coin_value = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 60));
         confirm_button = ($urandom_range(0, 99) < 20);
         cancel_button  = ($urandom_range(0, 99) < 5);
         product_sel    = 2'($urandom_range(0, 3));
         restock_valid  = ($urandom_range(0, 99) < 12);
         restock_sel    = 2'($urandom_range(0, 3));
         restock_count  = 4'($urandom_range(0, 15));
         step();
         vectors++; if (state !== 3'(m_st) || coin_total !== 8'(m_credit)) begin miscompares++; $display("[TB] FAIL rnd_state cyc %0d: got state=%0d total=%0d expected %0d/%0d", c, state, coin_total, m_st, m_credit); end
         vectors++; if (change_valid !== m_cv || change !== 8'(m_change)) begin miscompares++; $display("[TB] FAIL rnd_change cyc %0d: got cv=%0d change=%0d expected %0d/%0d", c, change_valid, change, m_cv, m_change); end
         vectors++; if (product_dispensed !== m_pd || dispensed_sel !== 2'(m_dsel)) begin miscompares++; $display("[TB] FAIL rnd_dispense cyc %0d: got pd=%0d sel=%0d expected %0d/%0d", c, product_dispensed, dispensed_sel, m_pd, m_dsel); end
         vectors++; if (alarm !== m_alarm || alarm_code !== 2'(m_code)) begin miscompares++; $display("[TB] FAIL rnd_alarm cyc %0d: got alarm=%0d code=%0d expected %0d/%0d", c, alarm, alarm_code, m_alarm, m_code); end
         vectors++; if (sold_out !== m_sold || total_sales !== 16'(m_sales)) begin miscompares++; $display("[TB] FAIL rnd_stock cyc %0d: got sold_out=%b sales=%0d expected %b/%0d", c, sold_out, total_sales, m_sold, m_sales); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_restock_vend();
      test_insufficient();
      test_sold_out();
      test_overflow();
      test_timeout();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
